// File: rtl/uart_tx.sv
// uart_tx -- serial UART transmitter driven by the x8 oversampled clock.
//
// Frame: start bit (0), 1..16 data bits LSB first, optional parity bit,
// one stop bit (1). Each serial bit is held for bit_cycles clock_x8 cycles.
//
// Ports:
//   clock_x8   in   8x baud clock, all logic on its rising edge
//   reset      in   synchronous active-low reset
//   parity[1:0] in  [1] parity enable, [0] 0=even 1=odd
//   width[3:0] in   data bits per frame, 0 means 16
//   bits[15:0] in   data word, bit 0 sent first
//   need_send  in   request to transmit bits (taken only while ready)
//   ready      out  idle, request will be accepted on the next edge
//   sent       out  one-cycle pulse when the stop bit completes
//   out        out  serial TX line, idle high
module uart_tx #(
  parameter int bit_cycles = 8
) (
  input  logic        clock_x8,
  input  logic        reset,
  input  logic [1:0]  parity,
  input  logic [3:0]  width,
  input  logic [15:0] bits,
  input  logic        need_send,
  output logic        ready,
  output logic        sent,
  output logic        out
);

  localparam logic [2:0] LAST = 3'(bit_cycles - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      r_state;
  logic [2:0]  r_step;
  logic [3:0]  r_i;
  logic        r_check;
  logic [15:0] r_shift;
  logic [3:0]  r_w;
  logic [1:0]  r_p;

  logic        w_last;
  logic [3:0]  w_i_nxt;
  logic        w_check_nxt;

  assign w_last      = (r_step == LAST);
  // 4-bit wrap makes width 0 end after 16 bits without special casing
  assign w_i_nxt     = r_i + 4'd1;
  assign w_check_nxt = r_check ^ r_shift[r_i];

  // Outputs are computed for the state being entered so they stay registered
  // and change on the same edge as the state.
  always_ff @(posedge clock_x8) begin
    if (!reset) begin
      r_state <= IDLE;
      r_step  <= 3'd0;
      r_i     <= 4'd0;
      r_check <= 1'b0;
      r_shift <= 16'd0;
      r_w     <= 4'd0;
      r_p     <= 2'd0;
      out     <= 1'b1;
      ready   <= 1'b1;
      sent    <= 1'b0;
    end else begin
      sent <= 1'b0;
      case (r_state)
        IDLE: begin
          out   <= 1'b1;
          ready <= 1'b1;
          r_step <= 3'd0;
          if (need_send) begin
            r_shift <= bits;
            r_w     <= width;
            r_p     <= parity;
            r_i     <= 4'd0;
            r_check <= 1'b0;
            r_state <= START;
            out     <= 1'b0;
            ready   <= 1'b0;
          end
        end
        START: begin
          r_step <= r_step + 3'd1;
          if (w_last) begin
            r_step  <= 3'd0;
            r_state <= DATA;
            out     <= r_shift[r_i];
          end
        end
        DATA: begin
          r_step <= r_step + 3'd1;
          if (w_last) begin
            r_step  <= 3'd0;
            r_check <= w_check_nxt;
            r_i     <= w_i_nxt;
            if (w_i_nxt == r_w) begin
              if (r_p[1]) begin
                r_state <= PARITY;
                out     <= w_check_nxt ^ r_p[0];
              end else begin
                r_state <= STOP;
                out     <= 1'b1;
              end
            end else begin
              out <= r_shift[w_i_nxt];
            end
          end
        end
        PARITY: begin
          r_step <= r_step + 3'd1;
          if (w_last) begin
            r_step  <= 3'd0;
            r_state <= STOP;
            out     <= 1'b1;
          end
        end
        STOP: begin
          r_step <= r_step + 3'd1;
          if (w_last) begin
            r_step  <= 3'd0;
            r_state <= IDLE;
            out     <= 1'b1;
            ready   <= 1'b1;
            sent    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_step  <= 3'd0;
          out     <= 1'b1;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  parity;
  logic [3:0]  width;
  logic [15:0] bits;
  logic        need_send;
  logic        ready, sent, out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.bit_cycles(8)) dut (
    .clock_x8 (clk),
    .reset    (rst_n),
    .parity   (parity),
    .width    (width),
    .bits     (bits),
    .need_send(need_send),
    .ready    (ready),
    .sent     (sent),
    .out      (out)
  );

  // seq[j] is serial bit j of the frame (j=0 start bit), nb bits in total
  typedef struct {
    logic [1:0]  par;
    logic [3:0]  wid;
    logic [15:0] dat;
    int          nb;
    logic [19:0] seq;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference frame builder for the random frames
  function automatic void build(input logic [1:0] p, input logic [3:0] w,
                                input logic [15:0] d, output int nb,
                                output logic [19:0] seq);
    int wn;
    logic par;
    wn  = (w == 4'd0) ? 16 : int'(w);
    seq = '0;
    par = p[0];
    for (int j = 0; j < wn; j++) begin
      seq[1+j] = d[j];
      par ^= d[j];
    end
    nb = 1 + wn;
    if (p[1]) begin
      seq[nb] = par;
      nb++;
    end
    seq[nb] = 1'b1;
    nb++;
  endfunction

  // Runs one frame and checks every cycle of it. With apply=0 the request
  // is assumed already high so the accept edge is the very next edge.
  task automatic run_frame(input logic [1:0] p, input logic [3:0] w,
                           input logic [15:0] d, input int nb,
                           input logic [19:0] seq, input bit apply,
                           input bit hold, input bit mid_en,
                           input logic [15:0] mid_bits);
    if (apply) begin
      @(negedge clk);
      chk("ready_before_accept", 32'(ready), 32'd1);
      parity    = p;
      width     = w;
      bits      = d;
      need_send = 1'b1;
    end
    @(posedge clk); #1;
    for (int c = 0; c < nb * 8; c++) begin
      chk("frame_out_ready_sent", 32'({out, ready, sent}), 32'({seq[c/8], 2'b00}));
      if (c == 0 && !hold) need_send = 1'b0;
      if (mid_en && c == 40) bits = mid_bits;
      @(posedge clk); #1;
    end
    chk("frame_end_sent", 32'({out, ready, sent}), 32'b111);
    if (!hold) begin
      @(posedge clk); #1;
      chk("idle_after_sent", 32'({out, ready, sent}), 32'b110);
    end
  endtask

  initial begin
    int nb;
    logic [19:0] seq;
    logic [1:0] rp;
    logic [3:0] rw;
    logic [15:0] rd;

    vecs[0] = '{2'b00, 4'd8,  16'h00A5, 10, 20'h0034A};
    vecs[1] = '{2'b10, 4'd8,  16'h00A5, 11, 20'h0054A};
    vecs[2] = '{2'b11, 4'd8,  16'h00A5, 11, 20'h0074A};
    vecs[3] = '{2'b00, 4'd0,  16'h8001, 18, 20'h30002};
    vecs[4] = '{2'b11, 4'd1,  16'hFFFE, 4,  20'h0000C};
    vecs[5] = '{2'b10, 4'd15, 16'h7FFF, 18, 20'h3FFFE};
    vecs[6] = '{2'b00, 4'd3,  16'hFFF5, 5,  20'h0001A};

    rst_n = 1'b0; parity = 2'b00; width = 4'd8; bits = 16'h0; need_send = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_state", 32'({out, ready, sent}), 32'b110);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("idle_no_request", 32'({out, ready, sent}), 32'b110);
    end

    // Directed table
    for (int v = 0; v < 7; v++)
      run_frame(vecs[v].par, vecs[v].wid, vecs[v].dat, vecs[v].nb, vecs[v].seq,
                1'b1, 1'b0, 1'b0, 16'h0);

    // Request held high: second frame starts one idle cycle after sent and
    // carries the word present at its own accept, not at the first accept.
    run_frame(2'b00, 4'd8, 16'h00A5, 10, 20'h0034A, 1'b1, 1'b1, 1'b1, 16'h005A);
    run_frame(2'b00, 4'd8, 16'h005A, 10, 20'h002B4, 1'b0, 1'b0, 1'b1, 16'hFFFF);

    // Reset during DATA aborts the frame
    @(negedge clk);
    parity = 2'b00; width = 4'd8; bits = 16'h00A5; need_send = 1'b1;
    @(posedge clk); #1;
    need_send = 1'b0;
    for (int c = 0; c < 20; c++) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_mid_frame", 32'({out, ready, sent}), 32'b110);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      chk("no_sent_after_abort", 32'({out, ready, sent}), 32'b110);
    end
    run_frame(vecs[0].par, vecs[0].wid, vecs[0].dat, vecs[0].nb, vecs[0].seq,
              1'b1, 1'b0, 1'b0, 16'h0);

    // Reset wins over a simultaneous request
    @(negedge clk); rst_n = 1'b0; need_send = 1'b1;
    @(posedge clk); #1;
    chk("reset_over_request", 32'({out, ready, sent}), 32'b110);
    @(negedge clk); rst_n = 1'b1; need_send = 1'b0;
    @(posedge clk); #1;
    chk("no_start_after_reset", 32'({out, ready, sent}), 32'b110);

    // Random frames against the reference builder
    for (int f = 0; f < 200; f++) begin
      rp = 2'($urandom_range(0, 3));
      rw = 4'($urandom_range(0, 15));
      rd = 16'($urandom);
      build(rp, rw, rd, nb, seq);
      run_frame(rp, rw, rd, nb, seq, 1'b1, 1'b0, 1'b0, 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the design's UART receiver, sharing its ×8 oversampled clock, frame format and configuration encoding. It accepts a parallel word of 1–16 bits through a ready/request handshake. It shifts the word out LSB-first as start bit, data bits, optional parity bit and one stop bit, holding each bit for exactly 8 `clock_x8` cycles. The block sits between the core's I/O register file and the TX pin.

## Interface
Parameters:
- `bit_cycles`, 8: `clock_x8` cycles per serial bit. Fixed at 8 to match the receiver; not intended to be overridden.

Ports (one clock; reset is synchronous and active-low):
- `clock_x8`  input  1: 8× baud clock; all logic on its rising edge.
- `reset`  input  1: synchronous, active-low reset, sampled on the `clock_x8` rising edge.
- `parity`  input  2: `[1]` = parity bit enabled; `[0]` = 0 even, 1 odd.
- `width`  input  4: data bits per frame; 1–15 literal, 0 means 16.
- `bits`  input  16: data word; bit 0 is sent first, bits at index ≥ width are ignored.
- `need_send`  input  1: request to transmit `bits`.
- `ready`  output  1: block idle and able to accept a request.
- `sent`  output  1: one-cycle pulse when a frame's stop bit has completed.
- `out`  output  1: serial TX line; idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Internal registers: 3-bit `step` counter, 4-bit bit index `i`, `check` parity accumulator, and latched `shift[15:0]`, `w[3:0]`, `p[1:0]`.
- IDLE:
  - `out`=1, `ready`=1.
  - When `need_send`=1 at an edge, latch `bits`/`width`/`parity` into `shift`/`w`/`p`.
  - Clear `i`, `check` and `step`; go to START.
- START: `out`=0 for 8 cycles, then go to DATA.
- DATA:
  - `out`=`shift[i]` for 8 cycles.
  - At the end of each bit: `check ^= shift[i]`, then `i` = `i`+1 (4-bit wrap).
  - When the incremented `i` == `w`, go to PARITY if `p[1]`, else STOP.
  - `w`=0 therefore yields 16 bits.
- PARITY: `out` = `check ^ p[0]` for 8 cycles, then go to STOP.
- STOP: `out`=1 for 8 cycles, then go to IDLE with a `sent` pulse.
- `need_send` outside IDLE is ignored and never queued.
- Input changes mid-frame have no effect, since only the latched copies are used.
- Frame length N = 8·(2 + W + P) cycles, where W = width (16 if 0) and P = `parity[1]`.

## Timing
- Reset values (next edge with `reset`=0): `out`=1, `ready`=1, `sent`=0, state=IDLE, `step`=0, `i`=0, `check`=0.
- Reset mid-frame aborts the frame: `out`=1 after that edge and no `sent` pulse.
- Reset takes priority over `need_send` in the same cycle.
- Accept edge k: `need_send`=1 and `ready`=1 sampled at k. After edge k, `out`=0 and `ready`=0.
- Bit j of the frame (j=0 is the start bit) drives `out` after edges k+8j through k+8j+7.
- At edge k+N: state=IDLE, `ready`=1, `sent`=1 for exactly one cycle, `out` stays 1.
- Earliest next accept is edge k+N+1, so back-to-back frames have one extra idle-high cycle between the stop bit and the next start bit.
- `out` and `ready` are registered outputs with no combinational path from the inputs.
- `ready` is low from edge k+1 through edge k+N−1 inclusive.

## Test plan
- Reset release, no request, 20 cycles → `out`=1, `ready`=1, `sent`=0 throughout.
- width=8, parity=00, bits=0x00A5 → `out` = 0,1,0,1,0,0,1,0,1,1, each for 8 cycles. `sent` pulses at k+80 and `ready`=1 from k+80.
- width=8, bits=0xA5, parity=10 then 11 → parity bit is 0 (even), then 1 (odd); frame = 88 cycles.
- width=0, parity=00, bits=0x8001 → start bit, then 1, fourteen 0s, 1, then stop; frame = 144 cycles.
- `need_send` held high continuously with bits changed mid-frame → each frame carries the word latched at accept.
  - Second start bit begins at k+81 (one idle cycle).
  - Mid-frame input changes do not alter `out`.
- Reset asserted for 1 cycle during DATA → `out`=1 and `ready`=1 on the next edge, no `sent` pulse. A new request then produces a clean full frame.
- Loopback into the receiver with random width/parity/data over 200 frames → receiver data matches, with no parity or stop-bit errors.
